// File: rtl/ula_sequenciador_pkg.sv
// Shared encodings for the ULA command sequencer: FSM states and the
// opcode map understood by the ULA decoder.
package ula_sequenciador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } estado_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_CMP  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_NEGA = 3'd6,
    OP_NEGB = 3'd7
  } opcode_t;

  localparam int OP_W = 3;

  // Latency counter width; never zero, even when LAT=1.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/ula_sequenciador_fila_cmd.sv
// Synchronous command FIFO; a full flag tells a full queue from an empty one
// because the pointers are equal in both cases.
module ula_fila_cmd #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q) && !full_q;
  assign full_o  = full_q;
  assign dout_o  = mem_q[rd_q];

  // No bypass: a full queue refuses a push even while it is being popped.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d   = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d   = do_pop  ? rd_q + PTR_W'(1) : rd_q;
    full_d = full_q;
    if (do_push && !do_pop) begin
      full_d = (wr_d == rd_q);
    end else if (do_pop && !do_push) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ula_sequenciador.sv
// Initiator side of the ULA operand/result interface: queues commands, drives
// the ULA for its fixed latency and returns each result with its opcode.
module ula_sequenciador
  import ula_sequenciador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LAT   = 4
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_A,
  input  logic [WIDTH-1:0] cmd_B,
  input  logic [OP_W-1:0]  cmd_op,
  output logic [WIDTH-1:0] ula_A,
  output logic [WIDTH-1:0] ula_B,
  output logic [OP_W-1:0]  ula_OPCODE,
  output logic             ula_EN,
  input  logic [WIDTH:0]   ula_s,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_data,
  output logic [OP_W-1:0]  res_op,
  output logic             busy,
  output logic [7:0]       done_count
);

  localparam int CMD_W = 2 * WIDTH + OP_W;
  localparam int CNT_W = cnt_width(LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  estado_t          estado_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] ula_A_q, ula_B_q;
  logic [OP_W-1:0]  ula_op_q;
  logic             ula_en_q;
  logic             res_valid_q;
  logic [WIDTH:0]   res_data_q;
  logic [OP_W-1:0]  res_op_q;
  logic [7:0]       done_q;

  logic [CMD_W-1:0] fifo_head;
  logic [WIDTH-1:0] head_a, head_b;
  logic [OP_W-1:0]  head_op;
  logic             fifo_full, fifo_empty;
  logic             pop;
  logic             captura;

  assign cmd_ready = !fifo_full;
  assign pop       = (estado_q == ST_IDLE) && !fifo_empty;
  assign {head_op, head_a, head_b} = fifo_head;

  ula_fila_cmd #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fila (
    .clk     (clk),
    .CLR     (CLR),
    .push_i  (cmd_valid && cmd_ready),
    .pop_i   (pop),
    .din_i   ({cmd_op, cmd_A, cmd_B}),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // With LAT=1 the ISSUE cycle itself is the capture cycle.
  assign captura = ((estado_q == ST_ISSUE) && (LAT == 1)) ||
                   ((estado_q == ST_WAIT) && (cnt_q == '0));

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      estado_q    <= ST_IDLE;
      cnt_q       <= '0;
      ula_A_q     <= '0;
      ula_B_q     <= '0;
      ula_op_q    <= '0;
      ula_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      done_q      <= '0;
    end else begin
      case (estado_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            ula_A_q  <= head_a;
            ula_B_q  <= head_b;
            ula_op_q <= head_op;
            cnt_q    <= CNT_INIT;
            // EN is high exactly LAT cycles before the capture edge, so for
            // LAT>1 it rises on the ISSUE edge, for LAT=1 on the pop edge.
            ula_en_q <= (LAT == 1);
            estado_q <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (captura) begin
            res_data_q  <= ula_s;
            res_op_q    <= ula_op_q;
            res_valid_q <= 1'b1;
            ula_en_q    <= 1'b0;
            estado_q    <= ST_RESP;
          end else if (estado_q == ST_ISSUE) begin
            ula_en_q <= 1'b1;
            estado_q <= ST_WAIT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            done_q      <= done_q + 8'd1;
            estado_q    <= ST_IDLE;
          end
        end
        default: estado_q <= ST_IDLE;
      endcase
    end
  end

  assign ula_A      = ula_A_q;
  assign ula_B      = ula_B_q;
  assign ula_OPCODE = ula_op_q;
  assign ula_EN     = ula_en_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign done_count = done_q;
  assign busy       = (estado_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with a behavioural ULA (add for op 0,
// A&B otherwise); one instance with LAT=4 and one with LAT=1.
module tb_ula_sequenciador;

  logic       clk;
  logic       CLR;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  // LAT=4 instance
  logic       cmd_valid, cmd_ready, ula_EN, res_valid, res_ready, busy;
  logic [7:0] cmd_A, cmd_B, ula_A, ula_B, done_count;
  logic [2:0] cmd_op, ula_OPCODE, res_op;
  logic [8:0] ula_s, res_data;

  // LAT=1 instance
  logic       cmd1_valid, cmd1_ready, ula1_EN, res1_valid, res1_ready, busy1;
  logic [7:0] cmd1_A, cmd1_B, ula1_A, ula1_B, done1_count;
  logic [2:0] cmd1_op, ula1_OPCODE, res1_op;
  logic [8:0] ula1_s, res1_data;

  logic [11:0] sb[$];
  logic [11:0] sb1[$];

  function automatic logic [8:0] ula_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    return (op == 3'd0) ? ({1'b0, a} + {1'b0, b}) : {1'b0, a & b};
  endfunction

  assign ula_s  = ula_model(ula_A, ula_B, ula_OPCODE);
  assign ula1_s = ula_model(ula1_A, ula1_B, ula1_OPCODE);

  ula_sequenciador #(.WIDTH(8), .DEPTH(4), .LAT(4)) dut (
    .clk(clk), .CLR(CLR),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_op(cmd_op),
    .ula_A(ula_A), .ula_B(ula_B), .ula_OPCODE(ula_OPCODE), .ula_EN(ula_EN),
    .ula_s(ula_s),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .busy(busy), .done_count(done_count)
  );

  ula_sequenciador #(.WIDTH(8), .DEPTH(4), .LAT(1)) dut1 (
    .clk(clk), .CLR(CLR),
    .cmd_valid(cmd1_valid), .cmd_ready(cmd1_ready),
    .cmd_A(cmd1_A), .cmd_B(cmd1_B), .cmd_op(cmd1_op),
    .ula_A(ula1_A), .ula_B(ula1_B), .ula_OPCODE(ula1_OPCODE), .ula_EN(ula1_EN),
    .ula_s(ula1_s),
    .res_valid(res1_valid), .res_ready(res1_ready),
    .res_data(res1_data), .res_op(res1_op),
    .busy(busy1), .done_count(done1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor, LAT=4 instance ----------------
  logic       en_prev = 1'b0;
  int         en_run = 0;
  logic [7:0] prev_A, prev_B;
  logic [2:0] prev_op;
  logic [8:0] last_res = '0;
  logic [11:0] exp_item;
  int         last_hs = -1;
  logic       spacing_on = 1'b0;

  always @(negedge clk) begin
    if (CLR) begin
      en_prev = 1'b0;
      en_run  = 0;
    end else begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_result: observed 0x%0h expected none", {res_op, res_data});
        end else begin
          exp_item = sb.pop_front();
          chk("result", {20'd0, res_op, res_data}, {20'd0, exp_item});
        end
        last_res = res_data;
        if (spacing_on && last_hs >= 0) chk("spacing", cyc - last_hs, 7);
        last_hs = cyc;
      end
      if (ula_EN) begin
        if (en_prev) chk("operands_stable", {13'd0, ula_OPCODE, ula_A, ula_B},
                         {13'd0, prev_op, prev_A, prev_B});
        en_run++;
      end else if (en_prev) begin
        chk("en_width", en_run, 4);
        en_run = 0;
      end
      en_prev = ula_EN;
      prev_A  = ula_A;
      prev_B  = ula_B;
      prev_op = ula_OPCODE;
    end
  end

  // ---------------- monitor, LAT=1 instance ----------------
  logic        en1_prev = 1'b0;
  int          en1_run = 0;
  logic [11:0] exp1_item;

  always @(negedge clk) begin
    if (CLR) begin
      en1_prev = 1'b0;
      en1_run  = 0;
    end else begin
      if (res1_valid && res1_ready) begin
        if (sb1.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_result1: observed 0x%0h expected none", {res1_op, res1_data});
        end else begin
          exp1_item = sb1.pop_front();
          chk("result_lat1", {20'd0, res1_op, res1_data}, {20'd0, exp1_item});
        end
      end
      if (ula1_EN) en1_run++;
      else if (en1_prev) begin
        chk("en_width_lat1", en1_run, 1);
        en1_run = 0;
      end
      en1_prev = ula1_EN;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int k;
    k = 0;
    cmd_A = a; cmd_B = b; cmd_op = op; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_accept", cmd_ready, 1);
    if (cmd_ready) sb.push_back({op, ula_model(a, b, op)});
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int k;
    k = 0;
    cmd1_A = a; cmd1_B = b; cmd1_op = op; cmd1_valid = 1'b1;
    @(negedge clk);
    while (!cmd1_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("cmd1_accept", cmd1_ready, 1);
    if (cmd1_ready) sb1.push_back({op, ula_model(a, b, op)});
    @(posedge clk); #2;
    cmd1_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", (k < 3000), 1);
    @(posedge clk); #2;
  endtask

  task automatic drain1();
    int k;
    k = 0;
    @(negedge clk);
    while ((sb1.size() != 0 || busy1) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain1_done", (k < 3000), 1);
    @(posedge clk); #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         edges;
    int         stable;
    int         stale;
    logic [8:0] rd;
    logic [2:0] rop;

    CLR = 1'b1;
    cmd_valid = 1'b0; cmd_A = '0; cmd_B = '0; cmd_op = '0; res_ready = 1'b0;
    cmd1_valid = 1'b0; cmd1_A = '0; cmd1_B = '0; cmd1_op = '0; res1_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_ula", {ula_EN, ula_OPCODE, ula_A, ula_B}, 0);
    chk("rst_res", {res_valid, res_op, res_data}, 0);
    chk("rst_busy_done", {busy, done_count}, 0);
    @(posedge clk); #2;
    CLR = 1'b0;

    // 1: single add, latency and completion count
    res_ready = 1'b1;
    send(8'h0F, 8'h01, 3'd0);
    edges = 0;
    while (edges < 20) begin
      @(negedge clk);
      if (res_valid) break;
      edges++;
    end
    chk("first_latency", edges, 6);
    chk("first_data", {res_op, res_data}, {3'd0, 9'h010});
    @(negedge clk);
    chk("first_done", done_count, 1);
    chk("first_res_valid_low", res_valid, 0);
    @(posedge clk); #2;

    // 2: carry into bit 8
    send(8'hFF, 8'h01, 3'd0);
    drain();
    chk("overflow", last_res, 9'h100);
    chk("done_2", done_count, 2);

    // 3: back-pressure with the consumer stalled
    res_ready = 1'b0;
    send(8'h11, 8'h22, 3'd0);
    send(8'h33, 8'h0F, 3'd3);
    send(8'hA5, 8'h5A, 3'd5);
    send(8'hF0, 8'h0F, 3'd0);
    send(8'hC3, 8'hFF, 3'd7);
    cmd_A = 8'h77; cmd_B = 8'h08; cmd_op = 3'd0; cmd_valid = 1'b1;
    edges = 0;
    while (!res_valid && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    chk("stall_res_valid", res_valid, 1);
    chk("stall_cmd_ready", cmd_ready, 0);
    rd = res_data;
    rop = res_op;
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid && res_data == rd && res_op == rop && !cmd_ready) stable++;
    end
    chk("hold_20", stable, 20);
    @(posedge clk); #2;
    res_ready = 1'b1;
    send(8'h77, 8'h08, 3'd0);
    drain();
    chk("done_8", done_count, 8);

    // 4: continuous stream, fixed spacing
    spacing_on = 1'b1;
    last_hs = -1;
    for (int i = 0; i < 5; i++) send(8'(i * 37 + 5), 8'(8'hE1 - i * 3), 3'(i));
    drain();
    spacing_on = 1'b0;
    chk("done_13", done_count, 13);

    // 5: clear in the middle of WAIT with commands queued
    send(8'h01, 8'h02, 3'd0);
    send(8'h03, 8'h04, 3'd0);
    send(8'h05, 8'h06, 3'd0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("pre_clr_en", {ula_EN, busy}, 2'b11);
    #1;
    CLR = 1'b1;
    #1;
    chk("clr_async", {ula_EN, res_valid, busy}, 0);
    chk("clr_ready", cmd_ready, 1);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #2;
    CLR = 1'b0;
    @(negedge clk);
    chk("post_clr_idle", {busy, cmd_ready, done_count}, {1'b0, 1'b1, 8'd0});
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid || ula_EN || busy) stale++;
    end
    chk("no_stale", stale, 0);
    @(posedge clk); #2;

    // 6: 256 completions wrap the counter
    for (int i = 0; i < 255; i++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    drain();
    chk("done_255", done_count, 255);
    send(8'h80, 8'h80, 3'd0);
    drain();
    chk("done_wrap", done_count, 0);
    chk("wrap_carry", last_res, 9'h100);

    // LAT=1 instance: single-cycle enable, all opcodes
    for (int i = 0; i < 8; i++) send1(8'(8'hF0 - i * 17), 8'(i * 29 + 3), 3'(i));
    drain1();
    chk("done_lat1", done1_count, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
